mxrv_csr_ctrl: RTL and testbench
================================

// Module: mxrv_csr_ctrl
// PURPOSE
//  Initiator side of the CSR register-file port: sequences Zicsr ops (CSRRW/CSRRS/CSRRC)
//  from execute into read/modify/write accesses on mxrv_csr_reg (addr/wdata/we -> rdata).
//  Returns old CSR value for rd; asserts hold toward mxrv_pc_reg while busy.
// PARAMETERS
//  ADDR_W    12  CSR address width (matches `CsrRegAddrBus)
//  DATA_W    32  CSR data width (matches `RegBus)
//  RO_CHECK  1   1: writes to addr[11:10]==2'b11 (read-only space) are suppressed and flagged
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid_i  in   1       execute presents a CSR op
//  req_ready_o  out  1       controller accepts op (IDLE only)
//  req_op_i     in   2       `CSR_OP_RW=2'b01, `CSR_OP_RS=2'b10, `CSR_OP_RC=2'b11; 2'b00 illegal
//  req_addr_i   in   ADDR_W  target CSR address
//  req_src_i    in   DATA_W  source operand (rs1 value or zero-extended uimm)
//  rsp_valid_o  out  1       response holds old CSR value
//  rsp_ready_i  in   1       consumer takes response
//  rsp_rdata_o  out  DATA_W  CSR value read before modification
//  rsp_err_o    out  1       illegal op, or write attempted to read-only CSR
//  csr_addr_o   out  ADDR_W  to mxrv_csr_reg.csr_addr_i
//  csr_we_o     out  1       to mxrv_csr_reg.we_i
//  csr_wdata_o  out  DATA_W  to mxrv_csr_reg.csr_wdata_i
//  csr_rdata_i  in   DATA_W  from mxrv_csr_reg.csr_rdata_o (combinational on addr)
//  hold_flag_o  out  1       to mxrv_pc_reg.hold_flag_i; 1 whenever state != IDLE
// BEHAVIOUR
//  - FSM states IDLE, READ, WRITE, RESP; all outputs decoded from state + latched request flops.
//  - Reset (async, rst_n=0): state=IDLE, csr_we_o=0, csr_addr_o=0, csr_wdata_o=0, rsp_valid_o=0,
//    rsp_rdata_o=0, rsp_err_o=0, hold_flag_o=0, req_ready_o=1. Reset mid-op aborts at once;
//    csr_we_o drops asynchronously, no partial write occurs after the reset edge.
//  - IDLE: req_ready_o=1; on req_valid_i latch op/addr/src -> READ (or RESP with err if op=00).
//  - READ (1 cycle): csr_addr_o=addr, csr_we_o=0; capture csr_rdata_i into old-value reg;
//    new = RW: src; RS: old|src; RC: old&~src.
//    Write needed = RW, or RS/RC with src!=0. If needed & RO_CHECK & addr[11:10]==2'b11:
//    no write, err=1 -> RESP. Else if needed -> WRITE, else -> RESP.
//  - WRITE (1 cycle): csr_addr_o=addr, csr_we_o=1, csr_wdata_o=new -> RESP.
//  - RESP: rsp_valid_o=1, rsp_rdata_o/rsp_err_o stable; on rsp_ready_i -> IDLE. Held indefinitely
//    under backpressure; no new request accepted until IDLE.
//  - Latency accept->rsp_valid: 2 cycles without write, 3 with write; 1 for illegal op.
//  - csr_we_o pulses exactly one cycle per written op; csr_addr_o/csr_wdata_o return to 0 in
//    IDLE/RESP. RESP->IDLE and IDLE accept are separate cycles (min 1 idle cycle between ops).
//  - Illegal op: rsp_rdata_o=0, rsp_err_o=1, no CSR access at all.
// STRUCTURE
//  - Add to mxrv_define.v: `CSR_OP_RW/RS/RC/NONE codes, FSM state encodings `CSR_ST_*.
//    Reuse `CsrRegAddrBus, `RegBus, `ZeroWord, `CSR_MISA, `CSR_MSTATUS.
//  - One natural sub-module: mxrv_csr_alu (combinational new-value + write-needed compute).
// TESTING (bench: mxrv_csr_ctrl + mxrv_csr_reg + mxrv_pc_reg, clk period 20ns)
//  1 Reset: hold rst_n=0 100ns -> all outputs at reset values, req_ready_o=1, hold_flag_o=0.
//  2 CSRRW mstatus(0x300) src=0x0000_1888 -> rsp_rdata_o=old mstatus, one we pulse, rsp at +3
//    cycles; then CSRRS src=0 on 0x300 -> rsp_rdata_o=0x0000_1888, no we pulse, rsp at +2.
//  3 CSRRS 0x300 src=0x8 then CSRRC src=0x1800 -> mstatus reads 0x0000_0088; hold_flag_o high
//    throughout each op, PC frozen.
//  4 CSRRW 0xF11 (mvendorid) src=0xDEAD_BEEF -> rsp_err_o=1, no we, value unchanged;
//    op=2'b00 -> rsp_err_o=1 after 1 cycle, csr_addr_o stays 0.
//  5 Backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o/rsp_rdata_o stable, req_ready_o=0,
//    second req_valid_i ignored until handshake.
//  6 Reset asserted during WRITE -> csr_we_o=0 same instant, FSM IDLE, target CSR reset value.

Source files
------------

// File: rtl/mxrv_csr_ctrl_pkg.sv
// Shared types and constants for the CSR access controller.
package mxrv_csr_ctrl_pkg;

    // Zicsr operation codes as presented by execute
    typedef enum logic [1:0] {
        CsrOpNone = 2'b00,
        CsrOpRw   = 2'b01,
        CsrOpRs   = 2'b10,
        CsrOpRc   = 2'b11
    } csr_op_e;

    // Controller sequencing states
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRead  = 2'b01,
        StWrite = 2'b10,
        StResp  = 2'b11
    } csr_state_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;

    // Top two address bits 2'b11 mark the read-only CSR space
    function automatic logic is_ro_space(input logic [1:0] addr_top);
        return addr_top == 2'b11;
    endfunction

endpackage

// File: rtl/mxrv_csr_ctrl_alu.sv
// Combinational new-value computation for CSRRW/CSRRS/CSRRC.
module mxrv_csr_ctrl_alu
    import mxrv_csr_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  csr_op_e           op,
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] src_val,
    output logic [DATA_W-1:0] new_val,
    output logic              write_needed
);

    // Set/clear with a zero source is a pure read and must not touch the CSR
    always_comb begin
        new_val      = old_val;
        write_needed = 1'b0;
        unique case (op)
            CsrOpRw: begin
                new_val      = src_val;
                write_needed = 1'b1;
            end
            CsrOpRs: begin
                new_val      = old_val | src_val;
                write_needed = |src_val;
            end
            CsrOpRc: begin
                new_val      = old_val & ~src_val;
                write_needed = |src_val;
            end
            CsrOpNone: begin
                new_val      = old_val;
                write_needed = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mxrv_csr_ctrl.sv
// Initiator side of the CSR register-file port: sequences one Zicsr op as
// read -> optional write -> response, stalling the PC while busy.
module mxrv_csr_ctrl
    import mxrv_csr_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter bit          RO_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_src_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] csr_addr_o,
    output logic              csr_we_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    input  logic [DATA_W-1:0] csr_rdata_i,
    output logic              hold_flag_o
);

    csr_state_e        state_q, state_d;
    csr_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] old_q, old_d;
    logic [DATA_W-1:0] new_q, new_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] alu_new;
    logic              alu_need;
    logic              ro_hit;

    mxrv_csr_ctrl_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op           (op_q),
        .old_val      (csr_rdata_i),
        .src_val      (src_q),
        .new_val      (alu_new),
        .write_needed (alu_need)
    );

    assign ro_hit = RO_CHECK && is_ro_space(addr_q[ADDR_W-1 -: 2]);

    // State and latched-request registers; reset aborts any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= CsrOpNone;
            addr_q  <= '0;
            src_q   <= '0;
            old_q   <= '0;
            new_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            old_q   <= old_d;
            new_q   <= new_d;
            err_q   <= err_d;
        end
    end

    // Next-state and request/response capture
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        src_d   = src_q;
        old_d   = old_q;
        new_d   = new_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    op_d   = csr_op_e'(req_op_i);
                    addr_d = req_addr_i;
                    src_d  = req_src_i;
                    new_d  = '0;
                    if (csr_op_e'(req_op_i) == CsrOpNone) begin
                        // Illegal op: answer straight away without touching the CSR port
                        old_d   = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                old_d = csr_rdata_i;
                new_d = alu_new;
                if (alu_need && ro_hit) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (alu_need) begin
                    state_d = StWrite;
                end else begin
                    state_d = StResp;
                end
            end
            StWrite: begin
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Port outputs decoded from state so reset removes csr_we_o immediately
    always_comb begin
        req_ready_o = 1'b0;
        hold_flag_o = 1'b1;
        csr_addr_o  = '0;
        csr_we_o    = 1'b0;
        csr_wdata_o = '0;
        rsp_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                hold_flag_o = 1'b0;
            end
            StRead: begin
                csr_addr_o = addr_q;
            end
            StWrite: begin
                csr_addr_o  = addr_q;
                csr_we_o    = 1'b1;
                csr_wdata_o = new_q;
            end
            StResp: begin
                rsp_valid_o = 1'b1;
            end
        endcase
    end

    assign rsp_rdata_o = old_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_mxrv_csr_ctrl.sv
// Directed bench for mxrv_csr_ctrl with small CSR-file and PC models.
module tb_mxrv_csr_ctrl;
    import mxrv_csr_ctrl_pkg::*;

    localparam logic [31:0] MISA_RST  = 32'h4000_1104;
    localparam logic [31:0] MVENDORID = 32'h0000_0612;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        hold_flag;

    logic [31:0] mstatus_q;
    logic [31:0] misa_q;
    logic [31:0] pc_q;
    int          we_cnt;

    int n_tests;
    int n_fail;

    mxrv_csr_ctrl #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .RO_CHECK (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_addr_i  (req_addr),
        .req_src_i   (req_src),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .csr_addr_o  (csr_addr),
        .csr_we_o    (csr_we),
        .csr_wdata_o (csr_wdata),
        .csr_rdata_i (csr_rdata),
        .hold_flag_o (hold_flag)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // CSR file model: writable mstatus/misa, read-only mvendorid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q <= 32'h0;
            misa_q    <= MISA_RST;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: mstatus_q <= csr_wdata;
                CSR_MISA:    misa_q    <= csr_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = mstatus_q;
            CSR_MISA:      csr_rdata = misa_q;
            CSR_MVENDORID: csr_rdata = MVENDORID;
            default:       csr_rdata = 32'h0;
        endcase
    end

    // PC model: advances by 4 each cycle unless held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pc_q <= 32'h0;
        else if (!hold_flag) pc_q <= pc_q + 32'd4;
    end

    initial we_cnt = 0;
    always @(posedge clk) begin
        if (csr_we === 1'b1) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for the response, then handshake it
    task automatic do_op(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int wes, output logic hold_ok, output logic pc_ok,
                         output logic [11:0] addr_or);
        int          we0;
        logic [31:0] pc0;
        we0      = we_cnt;
        hold_ok  = 1'b1;
        addr_or  = 12'h0;
        req_op   = op;
        req_addr = addr;
        req_src  = src;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat      = 1;
        pc0      = pc_q;
        hold_ok  = hold_ok & hold_flag;
        addr_or  = addr_or | csr_addr;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            hold_ok = hold_ok & hold_flag;
            addr_or = addr_or | csr_addr;
        end
        rdata     = rsp_rdata;
        err       = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        pc_ok = (pc_q === pc0);
        wes   = we_cnt - we0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          wes;
        logic        hok;
        logic        pok;
        logic [11:0] aor;
        int          we0;

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = 12'h0;
        req_src   = 32'h0;
        rsp_ready = 1'b0;

        // 1: reset values
        #99;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_hold", {31'h0, hold_flag}, 32'h0);
        chk("rst_we", {31'h0, csr_we}, 32'h0);
        chk("rst_addr", {20'h0, csr_addr}, 32'h0);
        chk("rst_wdata", csr_wdata, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'h0, rsp_err}, 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: CSRRW mstatus, then read-only CSRRS with zero source
        do_op(2'b01, 12'h300, 32'h0000_1888, lat, rd, er, wes, hok, pok, aor);
        chk("rw_rdata", rd, 32'h0);
        chk("rw_err", {31'h0, er}, 32'h0);
        chk("rw_lat", lat, 3);
        chk("rw_we", wes, 1);
        chk("rw_mstatus", mstatus_q, 32'h0000_1888);
        do_op(2'b10, 12'h300, 32'h0, lat, rd, er, wes, hok, pok, aor);
        chk("rs0_rdata", rd, 32'h0000_1888);
        chk("rs0_lat", lat, 2);
        chk("rs0_we", wes, 0);

        // 3: set then clear bits; PC must stay frozen during each op
        do_op(2'b10, 12'h300, 32'h8, lat, rd, er, wes, hok, pok, aor);
        chk("rs_rdata", rd, 32'h0000_1888);
        chk("rs_lat", lat, 3);
        chk("rs_we", wes, 1);
        chk("rs_hold", {31'h0, hok}, 32'h1);
        chk("rs_pc", {31'h0, pok}, 32'h1);
        do_op(2'b11, 12'h300, 32'h1800, lat, rd, er, wes, hok, pok, aor);
        chk("rc_rdata", rd, 32'h0000_1888);
        chk("rc_we", wes, 1);
        chk("rc_mstatus", mstatus_q, 32'h0000_0088);
        chk("rc_hold", {31'h0, hok}, 32'h1);
        chk("rc_pc", {31'h0, pok}, 32'h1);

        // 4: write to read-only space, then illegal op
        do_op(2'b01, 12'hF11, 32'hDEAD_BEEF, lat, rd, er, wes, hok, pok, aor);
        chk("ro_err", {31'h0, er}, 32'h1);
        chk("ro_we", wes, 0);
        chk("ro_rdata", rd, MVENDORID);
        chk("ro_lat", lat, 2);
        do_op(2'b00, 12'h300, 32'h5, lat, rd, er, wes, hok, pok, aor);
        chk("ill_err", {31'h0, er}, 32'h1);
        chk("ill_lat", lat, 1);
        chk("ill_rdata", rd, 32'h0);
        chk("ill_addr", {20'h0, aor}, 32'h0);
        chk("ill_we", wes, 0);
        chk("ill_mstatus", mstatus_q, 32'h0000_0088);

        // 5: response backpressure with a competing request
        we0       = we_cnt;
        req_op    = 2'b10;
        req_addr  = 12'h300;
        req_src   = 32'h0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        req_op    = 2'b01;
        req_src   = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("bp_rdata", rsp_rdata, 32'h0000_0088);
            chk("bp_ready", {31'h0, req_ready}, 32'h0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_idle", {31'h0, req_ready}, 32'h1);
        chk("bp_we", we_cnt - we0, 0);
        chk("bp_mstatus", mstatus_q, 32'h0000_0088);

        // 6: reset while in WRITE
        req_op    = 2'b01;
        req_addr  = 12'h300;
        req_src   = 32'h55;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("wr_we_before", {31'h0, csr_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("wr_rst_we", {31'h0, csr_we}, 32'h0);
        chk("wr_rst_ready", {31'h0, req_ready}, 32'h1);
        chk("wr_rst_hold", {31'h0, hold_flag}, 32'h0);
        chk("wr_rst_addr", {20'h0, csr_addr}, 32'h0);
        chk("wr_rst_mstatus", mstatus_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_mstatus", mstatus_q, 32'h0);
        chk("post_rst_valid", {31'h0, rsp_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
